// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared Hack sequencer state encoding and instruction bit positions
package pc_sequencer_pkg;
  typedef enum logic [2:0] {S_RST, S_IDLE, S_FETCH, S_EXEC, S_HALT, S_FAULT} state_t;
  localparam int CINSTR = 15;
  localparam int J1 = 2;
  localparam int J2 = 1;
  localparam int J3 = 0;
endpackage

// File: rtl/pc_sequencer_jump_cond.sv
// pc_sequencer_jump_cond: Hack jump decision from C-instruction flag, jump bits and ALU zr/ng
//   ci   in  instruction bit 15 (1 = C-instruction)
//   jmp  in  jump bits {J1,J2,J3} = {lt,eq,gt}
//   zr   in  ALU out == 0
//   ng   in  ALU out < 0
//   take out jump taken
module pc_sequencer_jump_cond (
  input  logic       ci,
  input  logic [2:0] jmp,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);
  assign take = ci & ((jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr));
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: Hack PC control master - fetches over ROM req/ack, issues one PC command per instruction
//   clock/reset_n          clock, async active-low reset
//   run                    execute when 1, park in IDLE when 0
//   pc_out                 PC feedback; pc_in/pc_load/pc_inc/pc_reset drive the PC register
//   rom_req/rom_ack/rom_data  instruction fetch handshake, address = pc_out
//   instr/instr_valid      latched instruction for the datapath; exec_stall holds EXEC
//   a_reg/zr/ng            jump target and ALU flags
//   halted                 self-loop halt (only with PC_HALT_DETECT_EN defined)
//   fault                  ROM ack timeout, sticky until reset
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_in,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             pc_reset,
  output logic             rom_req,
  input  logic             rom_ack,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             exec_stall,
  input  logic [WIDTH-1:0] a_reg,
  input  logic             zr,
  input  logic             ng,
  output logic             halted,
  output logic             fault
);
  localparam int CW = $clog2(ACK_TIMEOUT + 2);
  state_t state, next;
  logic [CW-1:0] cnt;
  logic take, self_loop, ack_to;
  pc_sequencer_jump_cond u_jc (.ci(instr[CINSTR]), .jmp(instr[J1:J3]), .zr, .ng, .take);
  assign ack_to = ACK_TIMEOUT != 0 && cnt + 1'b1 == CW'(ACK_TIMEOUT);
`ifdef PC_HALT_DETECT_EN
  assign self_loop = take && a_reg == pc_out;
  assign halted = state == S_HALT;
`else
  logic unused_pc;
  assign unused_pc = ^pc_out;
  assign self_loop = 1'b0;
  assign halted = 1'b0;
`endif
  // pc_reset is gated by reset_n so no command is asserted while reset is held
  assign pc_reset = state == S_RST && reset_n;
  assign rom_req = state == S_FETCH;
  assign instr_valid = state == S_EXEC;
  assign fault = state == S_FAULT;
  assign pc_in = a_reg;
  always_comb begin
    next = state;
    pc_load = 1'b0;
    pc_inc = 1'b0;
    case (state)
      S_RST:   next = S_IDLE;
      S_IDLE:  next = run ? S_FETCH : S_IDLE;
      S_FETCH: next = rom_ack ? S_EXEC : ack_to ? S_FAULT : S_FETCH;
      S_EXEC: if (!exec_stall) begin
        next = self_loop ? S_HALT : run ? S_FETCH : S_IDLE;
        pc_load = take & ~self_loop;
        pc_inc = ~take;
      end
      default: next = state;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RST;
      instr <= '0;
      cnt <= '0;
    end else begin
      state <= next;
      instr <= (state == S_FETCH && rom_ack) ? rom_data : instr;
      cnt <= (state == S_FETCH && !rom_ack) ? cnt + 1'b1 : '0;
    end
  end
endmodule
